// File: rtl/program_sequencer_stack_if.sv
// program_sequencer_stack_if: decoder/ALU/program-memory side bus of the program sequencer
//   inputs to sequencer : jmp, jmp_nz, dont_jmp, call, ret, ir_nibble, pm_ready
//   outputs of sequencer: pm_addr, pc, stack_level, stack_ovf, stack_unf
//   SEQ_BRANCH_COUNT_EN adds output branch_count
interface program_sequencer_stack_if #(
  parameter int PC_WIDTH = 8,
  parameter int SP_WIDTH = 2
);
  logic                jmp, jmp_nz, dont_jmp, call, ret, pm_ready;
  logic [3:0]          ir_nibble;
  logic [PC_WIDTH-1:0] pm_addr, pc;
  logic [SP_WIDTH:0]   stack_level;
  logic                stack_ovf, stack_unf;
`ifdef SEQ_BRANCH_COUNT_EN
  logic [15:0]         branch_count;
`endif
  modport master (
    output jmp, jmp_nz, dont_jmp, call, ret, ir_nibble, pm_ready,
    input  pm_addr, pc, stack_level, stack_ovf, stack_unf
`ifdef SEQ_BRANCH_COUNT_EN
    , input branch_count
`endif
  );
  modport slave (
    input  jmp, jmp_nz, dont_jmp, call, ret, ir_nibble, pm_ready,
    output pm_addr, pc, stack_level, stack_ovf, stack_unf
`ifdef SEQ_BRANCH_COUNT_EN
    , output branch_count
`endif
  );
endinterface

// File: rtl/program_sequencer_stack.sv
// program_sequencer_stack: pc/next-address generator with circular return-address stack
//   clk, sync_reset (sync, active-high) plain ports; bus (slave) carries strobes, pm_ready,
//   pm_addr (combinational), pc, stack_level, sticky stack_ovf/stack_unf.
//   SEQ_BRANCH_COUNT_EN adds a saturating 16-bit branch_count.
module program_sequencer_stack #(
  parameter int PC_WIDTH    = 8,
  parameter int STACK_DEPTH = 4,
  parameter int SP_WIDTH    = 2
) (
  input logic clk,
  input logic sync_reset,
  program_sequencer_stack_if.slave bus
);
  logic [PC_WIDTH-1:0] pc_q, pc1, tgt, addr;
  logic [PC_WIDTH-1:0] stk_q [STACK_DEPTH];
  logic [SP_WIDTH:0]   lvl_q, lvl_d;
  logic [SP_WIDTH-1:0] base_q, base_d, wr_idx, rd_idx;
  logic ovf_q, ovf_d, unf_q, unf_d, jump, live, push, pop, full;
  // base_q marks the oldest entry; a push when full overwrites it and advances base,
  // so wr_idx = base+level covers both the normal and the circular case.
  always_comb begin
    pc1    = pc_q + PC_WIDTH'(1);
    tgt    = {bus.ir_nibble, {(PC_WIDTH-4){1'b0}}};
    jump   = bus.jmp | (bus.jmp_nz & ~bus.dont_jmp);
    full   = lvl_q == (SP_WIDTH+1)'(STACK_DEPTH);
    wr_idx = base_q + lvl_q[SP_WIDTH-1:0];
    rd_idx = wr_idx - SP_WIDTH'(1);
    live   = bus.pm_ready & ~jump;
    push   = live & bus.call;
    pop    = live & ~bus.call & bus.ret & (lvl_q != '0);
    addr   = sync_reset ? '0 : ~bus.pm_ready ? pc_q : (jump | bus.call) ? tgt : pop ? stk_q[rd_idx] : pc1;
    lvl_d  = (push & ~full) ? lvl_q + (SP_WIDTH+1)'(1) : pop ? lvl_q - (SP_WIDTH+1)'(1) : lvl_q;
    base_d = (push & full) ? base_q + SP_WIDTH'(1) : base_q;
    ovf_d  = ovf_q | (push & full);
    unf_d  = unf_q | (live & ~bus.call & bus.ret & (lvl_q == '0));
  end
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      pc_q   <= '0;
      lvl_q  <= '0;
      base_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      pc_q   <= addr;
      lvl_q  <= lvl_d;
      base_q <= base_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end
  always_ff @(posedge clk)
    if (push & ~sync_reset) stk_q[wr_idx] <= pc1;
`ifdef SEQ_BRANCH_COUNT_EN
  logic [15:0] cnt_q, cnt_d;
  always_comb cnt_d = (bus.pm_ready & (jump | bus.call | pop) & ~&cnt_q) ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= sync_reset ? '0 : cnt_d;
  assign bus.branch_count = cnt_q;
`endif
  assign bus.pm_addr     = addr;
  assign bus.pc          = pc_q;
  assign bus.stack_level = lvl_q;
  assign bus.stack_ovf   = ovf_q;
  assign bus.stack_unf   = unf_q;
endmodule

// File: tb/tb_program_sequencer_stack.sv
// tb_program_sequencer_stack: directed table-driven bench for program_sequencer_stack
module tb_program_sequencer_stack;
  logic clk = 1'b0;
  logic sync_reset;
  always #5 clk = ~clk;
  program_sequencer_stack_if #(.PC_WIDTH(8), .SP_WIDTH(2)) bus ();
  program_sequencer_stack #(.PC_WIDTH(8), .STACK_DEPTH(4), .SP_WIDTH(2)) dut (
    .clk(clk), .sync_reset(sync_reset), .bus(bus)
  );
  typedef struct {
    logic rst, jmp, jnz, dz, call, ret, rdy;
    logic [3:0] nib;
    logic [7:0] addr;
    logic [2:0] lvl;
    logic ovf, unf;
  } vec_t;
  vec_t vq[$];
  int n_cmp = 0, n_bad = 0;
  logic e_ovf = 1'b0, e_unf = 1'b0;
  function automatic void add(input logic rst, j, jn, dz, c, r, rdy, input logic [3:0] nib,
                              input logic [7:0] a, input logic [2:0] l);
    vec_t v;
    v.rst = rst; v.jmp = j; v.jnz = jn; v.dz = dz; v.call = c; v.ret = r; v.rdy = rdy;
    v.nib = nib; v.addr = a; v.lvl = l; v.ovf = e_ovf; v.unf = e_unf;
    vq.push_back(v);
  endfunction
  function automatic void idle(input logic [7:0] a, input logic [2:0] l);
    add(0, 0, 0, 0, 0, 0, 1, 4'h0, a, l);
  endfunction
  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    sync_reset = v.rst; bus.jmp = v.jmp; bus.jmp_nz = v.jnz; bus.dont_jmp = v.dz;
    bus.call = v.call; bus.ret = v.ret; bus.pm_ready = v.rdy; bus.ir_nibble = v.nib;
    #1 chk("pm_addr", idx, bus.pm_addr, v.addr);
    @(posedge clk);
    #1;
    chk("pc", idx, bus.pc, v.addr);
    chk("stack_level", idx, 8'(bus.stack_level), 8'(v.lvl));
    chk("stack_ovf", idx, 8'(bus.stack_ovf), 8'(v.ovf));
    chk("stack_unf", idx, 8'(bus.stack_unf), 8'(v.unf));
  endtask
  task automatic step(input logic c, r, rdy, input logic [3:0] nib, input logic [7:0] a,
                      input logic [2:0] l, input int idx);
    vec_t v;
    v.rst = 0; v.jmp = 0; v.jnz = 0; v.dz = 0; v.call = c; v.ret = r; v.rdy = rdy;
    v.nib = nib; v.addr = a; v.lvl = l; v.ovf = 0; v.unf = 0;
    apply(v, idx);
  endtask
  initial begin
    sync_reset = 1'b1; bus.jmp = 0; bus.jmp_nz = 0; bus.dont_jmp = 0; bus.call = 0;
    bus.ret = 0; bus.pm_ready = 1; bus.ir_nibble = 4'h0;
    add(1, 0, 0, 0, 0, 0, 1, 4'h0, 8'h00, 0);
    idle(8'h01, 0); idle(8'h02, 0); idle(8'h03, 0); idle(8'h04, 0);
    add(0, 1, 0, 0, 0, 0, 1, 4'h1, 8'h10, 0);
    idle(8'h11, 0); idle(8'h12, 0);
    add(0, 1, 0, 0, 0, 0, 1, 4'h7, 8'h70, 0);
    add(0, 0, 1, 1, 0, 0, 1, 4'h3, 8'h71, 0);
    add(0, 0, 1, 0, 0, 0, 1, 4'h3, 8'h30, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 1, 0, 0, 4'h8, 8'h30, 0);
    add(0, 0, 0, 0, 1, 0, 1, 4'h8, 8'h80, 1);
    add(0, 0, 0, 0, 0, 1, 1, 4'h0, 8'h31, 0);
    add(0, 1, 0, 0, 0, 0, 1, 4'h2, 8'h20, 0);
    add(0, 0, 0, 0, 1, 0, 1, 4'h5, 8'h50, 1);
    idle(8'h51, 1); idle(8'h52, 1);
    add(0, 0, 0, 0, 1, 0, 1, 4'h9, 8'h90, 2);
    add(0, 0, 0, 0, 0, 1, 1, 4'h0, 8'h53, 1);
    add(0, 0, 0, 0, 0, 1, 1, 4'h0, 8'h21, 0);
    add(0, 1, 0, 0, 1, 0, 1, 4'h4, 8'h40, 0);
    add(0, 0, 0, 0, 1, 1, 1, 4'h6, 8'h60, 1);
    add(0, 0, 0, 0, 0, 1, 1, 4'h0, 8'h41, 0);
    add(0, 0, 1, 1, 1, 0, 1, 4'h2, 8'h20, 1);
    add(0, 0, 0, 0, 0, 1, 1, 4'h0, 8'h42, 0);
    add(0, 0, 0, 0, 1, 0, 1, 4'h1, 8'h10, 1);
    add(0, 0, 1, 0, 0, 1, 1, 4'h5, 8'h50, 1);
    add(0, 0, 0, 0, 0, 1, 1, 4'h0, 8'h43, 0);
    add(0, 0, 0, 0, 1, 0, 1, 4'hA, 8'hA0, 1);
    add(0, 0, 0, 0, 1, 0, 1, 4'hB, 8'hB0, 2);
    add(0, 0, 0, 0, 1, 0, 1, 4'hC, 8'hC0, 3);
    add(0, 0, 0, 0, 1, 0, 1, 4'hD, 8'hD0, 4);
    e_ovf = 1'b1;
    add(0, 0, 0, 0, 1, 0, 1, 4'hE, 8'hE0, 4);
    add(0, 0, 0, 0, 0, 1, 1, 4'h0, 8'hD1, 3);
    add(0, 0, 0, 0, 0, 1, 1, 4'h0, 8'hC1, 2);
    add(0, 0, 0, 0, 0, 1, 1, 4'h0, 8'hB1, 1);
    add(0, 0, 0, 0, 0, 1, 1, 4'h0, 8'hA1, 0);
    e_unf = 1'b1;
    add(0, 0, 0, 0, 0, 1, 1, 4'h0, 8'hA2, 0);
    add(0, 1, 0, 0, 0, 0, 1, 4'hF, 8'hF0, 0);
    for (int i = 1; i < 16; i++) idle(8'(8'hF0 + i), 0);
    idle(8'h00, 0);
    add(0, 0, 0, 0, 1, 0, 1, 4'h1, 8'h10, 1);
    add(0, 0, 0, 0, 1, 0, 1, 4'h2, 8'h20, 2);
    add(0, 0, 0, 0, 1, 0, 1, 4'h3, 8'h30, 3);
    e_ovf = 1'b0; e_unf = 1'b0;
    add(1, 0, 0, 0, 1, 0, 1, 4'h4, 8'h00, 0);
    idle(8'h01, 0);
    foreach (vq[i]) apply(vq[i], i);
    step(1, 0, 1, 4'h6, 8'h60, 1, 1000);
    step(0, 1, 0, 4'h0, 8'h60, 1, 1001);
    step(0, 1, 0, 4'h0, 8'h60, 1, 1002);
    step(0, 1, 1, 4'h0, 8'h02, 0, 1003);
    step(0, 0, 1, 4'h0, 8'h03, 0, 1004);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
